// File: rtl/mem_master.sv
// mem_master: initiator-side controller for a single-port synchronous block RAM with a
// one-cycle registered read. It accepts single/burst requests over valid/ready, drives the
// RAM write-enable, address and write-data lines, and returns read beats (or one write
// completion beat) over a valid/ready response channel.
// Optional feature macro: MEM_BOUND_CHECK_EN rejects bursts that would run past the last RAM
// word. Without it, bursts wrap modulo DEPTH and o_rsp_err stays 0.
module mem_master #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    // request channel
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [ADDR_W-1:0] i_req_len,
    input  logic [DATA_W-1:0] i_req_wdata,
    // response channel
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_last,
    output logic              o_rsp_err,
    // RAM side
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdIssue,
        StRdWait,
        StRsp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_last_q, rsp_last_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]   addr_inc;

    // Next beat address, wrapping modulo DEPTH
    always_comb begin
        addr_inc = (mem_addr_q == LastAddr) ? '0 : mem_addr_q + 1'b1;
    end

    // State register and registered outputs; reset aborts any burst and drops o_mem_we at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    cnt_d = i_req_len;
`ifdef MEM_BOUND_CHECK_EN
                    // Overflow test done one bit wider so addr+len cannot alias back in range
                    if (({1'b0, i_req_addr} + {1'b0, i_req_len}) > {1'b0, LastAddr}) begin
                        state_d     = StRsp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_last_d  = 1'b1;
                        rsp_rdata_d = '0;
                    end else
`endif
                    if (i_req_we) begin
                        state_d     = StWr;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = i_req_addr;
                        mem_wdata_d = i_req_wdata;
                    end else begin
                        state_d    = StRdIssue;
                        mem_addr_d = i_req_addr;
                    end
                end
            end
            StWr: begin
                if (cnt_q == '0) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_inc;
                    cnt_d      = cnt_q - 1'b1;
                end
            end
            StRdIssue: begin
                // RAM samples o_mem_addr at the edge closing this cycle
                state_d = StRdWait;
            end
            StRdWait: begin
                state_d     = StRsp;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = i_mem_rdata;
                rsp_last_d  = (cnt_q == '0);
            end
            StRsp: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        // Write completions and rejected requests are always single last beats
                        state_d    = StIdle;
                        rsp_last_d = 1'b0;
                        rsp_err_d  = 1'b0;
                    end else begin
                        state_d    = StRdIssue;
                        mem_addr_d = addr_inc;
                        cnt_d      = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_req_ready = (state_q == StIdle);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_last  = rsp_last_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized self-checking bench for mem_master. A behavioural RAM sits on the
// memory port; an array model of RAM contents predicts every read beat and write address.
// Honours MEM_BOUND_CHECK_EN when compiled with it.
module tb_mem_master;

    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;
`ifdef MEM_BOUND_CHECK_EN
    localparam bit BoundEn = 1'b1;
`else
    localparam bit BoundEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [AW-1:0] i_req_addr;
    logic [AW-1:0] i_req_len;
    logic [DW-1:0] i_req_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_last;
    logic          o_rsp_err;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    logic          ram_clr;

    always #5 clk = ~clk;

    mem_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_req_len  (i_req_len),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_last (o_rsp_last),
        .o_rsp_err  (o_rsp_err),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata)
    );

    // Single-port RAM with one-cycle registered read
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            ram_q <= '0;
        end else begin
            if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
            ram_q <= ram[o_mem_addr];
        end
    end
    assign i_mem_rdata = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit oob(input int addr, input int len);
        return BoundEn && ((addr + len) > (DEPTH - 1));
    endfunction

    // Random request traffic that a busy controller must ignore
    task automatic junk();
        i_req_valid = 1'($urandom_range(0, 1));
        i_req_we    = 1'($urandom_range(0, 1));
        i_req_addr  = AW'($urandom);
        i_req_len   = AW'($urandom);
        i_req_wdata = DW'($urandom);
    endtask

    // Called at a negedge while idle; returns at the negedge of the first cycle after acceptance
    task automatic start_req(input bit we, input int addr, input int len, input int data);
        check("idle_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = AW'(addr);
        i_req_len   = AW'(len);
        i_req_wdata = DW'(data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_txn();
        check("end_ready", o_req_ready, 1);
        check("end_valid", o_rsp_valid, 0);
        check("end_last", o_rsp_last, 0);
        check("end_err", o_rsp_err, 0);
        check("end_we", o_mem_we, 0);
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b0;
    endtask

    // Single-beat response (write completion or rejected request), with random backpressure
    task automatic finish_single(input bit err);
        int stall = $urandom_range(0, 2);
        check("cpl_valid", o_rsp_valid, 1);
        check("cpl_last", o_rsp_last, 1);
        check("cpl_rdata", o_rsp_rdata, 0);
        check("cpl_err", o_rsp_err, err);
        for (int s = 0; s < stall; s++) begin
            i_rsp_ready = 1'b0;
            junk();
            @(negedge clk);
            check("cpl_hold_valid", o_rsp_valid, 1);
            check("cpl_hold_last", o_rsp_last, 1);
            check("cpl_hold_we", o_mem_we, 0);
        end
        i_rsp_ready = 1'b1;
        junk();
        @(negedge clk);
        end_txn();
    endtask

    task automatic do_write(input int addr, input int len, input int data);
        bit bad = oob(addr, len);
        start_req(1'b1, addr, len, data);
        if (!bad) begin
            for (int i = 0; i <= len; i++) begin
                int a = (addr + i) % DEPTH;
                check("wr_we", o_mem_we, 1);
                check("wr_addr", o_mem_addr, a);
                check("wr_data", o_mem_wdata, data);
                check("wr_busy", o_req_ready, 0);
                model_mem[a] = DW'(data);
                junk();
                @(negedge clk);
            end
        end
        check("wr_we_done", o_mem_we, 0);
        finish_single(bad);
    endtask

    // stall0 >= 0 fixes the backpressure on the first beat; otherwise it is random
    task automatic do_read(input int addr, input int len, input int stall0);
        bit bad = oob(addr, len);
        start_req(1'b0, addr, len, 0);
        if (bad) begin
            check("rd_oob_we", o_mem_we, 0);
            finish_single(1'b1);
        end else begin
            for (int b = 0; b <= len; b++) begin
                int a = (addr + b) % DEPTH;
                int stall;
                check("rd_issue_addr", o_mem_addr, a);
                check("rd_issue_we", o_mem_we, 0);
                check("rd_issue_valid", o_rsp_valid, 0);
                check("rd_busy", o_req_ready, 0);
                junk();
                @(negedge clk);
                check("rd_wait_valid", o_rsp_valid, 0);
                junk();
                @(negedge clk);
                check("rd_valid", o_rsp_valid, 1);
                check("rd_data", o_rsp_rdata, model_mem[a]);
                check("rd_last", o_rsp_last, b == len);
                check("rd_err", o_rsp_err, 0);
                stall = (b == 0 && stall0 >= 0) ? stall0 : $urandom_range(0, 2);
                for (int s = 0; s < stall; s++) begin
                    i_rsp_ready = 1'b0;
                    junk();
                    @(negedge clk);
                    check("bp_valid", o_rsp_valid, 1);
                    check("bp_data", o_rsp_rdata, model_mem[a]);
                    check("bp_addr", o_mem_addr, a);
                    check("bp_we", o_mem_we, 0);
                end
                i_rsp_ready = 1'b1;
                junk();
                @(negedge clk);
            end
            end_txn();
        end
    endtask

    // Reset lands in the 2nd write cycle of a len=7 fill; only the first word gets written
    task automatic reset_mid_fill(input int addr, input int data);
        start_req(1'b1, addr, 7, data);
        i_req_valid = 1'b0;
        check("rstf_we1", o_mem_we, 1);
        check("rstf_addr1", o_mem_addr, addr);
        model_mem[addr] = DW'(data);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstf_we_drop", o_mem_we, 0);
        check("rstf_ready", o_req_ready, 1);
        check("rstf_valid", o_rsp_valid, 0);
        check("rstf_addr0", o_mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstf_idle", o_req_ready, 1);
        check("rstf_no_rsp", o_rsp_valid, 0);
    endtask

    initial begin
        rst         = 1'b1;
        ram_clr     = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_len   = '0;
        i_req_wdata = '0;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (2) @(negedge clk);

        check("rst_ready", o_req_ready, 1);
        check("rst_we", o_mem_we, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_wdata", o_mem_wdata, 0);
        check("rst_valid", o_rsp_valid, 0);
        check("rst_rdata", o_rsp_rdata, 0);
        check("rst_last", o_rsp_last, 0);
        check("rst_err", o_rsp_err, 0);
        ram_clr = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check("post_rst_ready", o_req_ready, 1);

        do_write(5, 0, 'h2A5);
        do_read(5, 0, 0);
        do_write(10, 3, 'h155);
        do_read(10, 3, 0);
        do_read(10, 1, 5);
        do_write(62, 3, 'h3FF);
        do_read(62, 1, -1);
        do_read(0, 1, -1);
        do_read(62, 3, -1);
        reset_mid_fill(20, 'h1C3);
        do_read(20, 7, -1);

        for (int n = 0; n < 40; n++) begin
            int addr = $urandom_range(0, DEPTH - 1);
            int len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                                    : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) do_write(addr, len, $urandom_range(0, 1023));
            else do_read(addr, len, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
